// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write path.
//   VRAM_ADDR_W / VRAM_DATA_W / PIX_W : ZBT address, ZBT word and pixel widths
//   X_W / Y_W                         : input coordinate counter widths
//   state_e                           : writer frame state
//   fifo_entry_t                      : one queued write {addr, pixel}
//   pack_addr()                       : {y, x} address layout shared with the display reader
package vram_pkg;

  localparam int VRAM_ADDR_W = 19;
  localparam int VRAM_DATA_W = 36;
  localparam int PIX_W       = 30;
  localparam int X_W         = 11;
  localparam int Y_W         = 10;
  localparam int FIFO_W      = VRAM_ADDR_W + PIX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [PIX_W-1:0]       pix;
  } fifo_entry_t;

  function automatic logic [VRAM_ADDR_W-1:0] pack_addr(input logic [8:0] y,
                                                       input logic [9:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous show-ahead FIFO buffering pixel writes until the arbiter
// grants a ZBT slot.
//   clk, rst_n      : clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data : write request and entry; ignored when full unless a pop
//                     happens in the same cycle
//   pop, pop_data   : read request; pop_data always shows the head entry
//   full, empty     : occupancy flags
// DEPTH must be a power of two (>= 2).
module vram_wr_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 49
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vram_writer.sv
// Writes a non-stallable pixel stream into ZBT VRAM using arbiter-granted
// write slots, buffering pixels in a small FIFO between grants.
//   clk, reset        : clock; asynchronous active-low reset
//   pix_valid/_data   : pixel stream (three 10-bit components), no backpressure
//   pix_sof, pix_eol  : frame start / line end qualifiers of pix_valid
//   wr_slot           : grant; the ZBT port is free for one write next cycle
//   vram_addr         : {y[8:0], x[9:0]}
//   vram_write_data   : {6'd0, pixel}
//   vram_we           : one-cycle write strobe per word
//   busy              : state is not IDLE
//   frame_done        : one-cycle pulse once the last frame word is written
//   ovf_count         : saturating dropped-pixel count, cleared on sof
// Build option: define VRAM_WRITER_OVF_CNT_EN to include the overflow
// counter; otherwise ovf_count is tied to zero.
module vram_writer
  import vram_pkg::*;
#(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   pix_sof,
  input  logic                   pix_eol,
  input  logic                   wr_slot,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic [VRAM_DATA_W-1:0] vram_write_data,
  output logic                   vram_we,
  output logic                   busy,
  output logic                   frame_done,
  output logic [15:0]            ovf_count
);

  localparam logic [X_W-1:0] X_LIM  = X_W'(WIDTH);
  localparam logic [Y_W-1:0] Y_LIM  = Y_W'(HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  state_e state_q, state_d;

  logic [X_W-1:0] x_q, x_d, x_cur;
  logic [Y_W-1:0] y_q, y_d, y_cur;

  logic [VRAM_ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [VRAM_DATA_W-1:0] vram_data_q, vram_data_d;
  logic                   vram_we_q, vram_we_d;

  logic        sof_v, eff_run, in_win, want_push, push, pop, last_pix;
  logic        fifo_full, fifo_empty;
  fifo_entry_t push_entry, pop_entry;

  // ---------------------------------------------------------------------------
  // Coordinate tracking and FIFO push/pop decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    sof_v = pix_valid && pix_sof;
    // x_q/y_q hold the coordinate of the next expected pixel; sof forces (0,0).
    x_cur = sof_v ? '0 : x_q;
    y_cur = sof_v ? '0 : y_q;
    // A sof pixel already belongs to the new frame's RUN period.
    eff_run   = sof_v || (state_q == ST_RUN);
    in_win    = (x_cur < X_LIM) && (y_cur < Y_LIM);
    want_push = pix_valid && eff_run && in_win;
    pop       = wr_slot && !fifo_empty;
    push      = want_push && (!fifo_full || pop);
    last_pix  = pix_valid && eff_run && (x_cur == X_LAST) && (y_cur == Y_LAST);

    push_entry.addr = pack_addr(y_cur[8:0], x_cur[9:0]);
    push_entry.pix  = pix_data;

    x_d = x_q;
    y_d = y_q;
    if (pix_valid) begin
      if (pix_eol) begin
        x_d = '0;
        y_d = (y_cur == '1) ? y_cur : y_cur + Y_W'(1);
      end else begin
        x_d = (x_cur == '1) ? x_cur : x_cur + X_W'(1);
        y_d = y_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // ZBT write port: one registered write per granted pop
  // ---------------------------------------------------------------------------
  always_comb begin
    vram_we_d   = pop;
    vram_addr_d = pop ? pop_entry.addr : vram_addr_q;
    vram_data_d = pop ? {6'd0, pop_entry.pix} : vram_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vram_we_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
    end else begin
      vram_we_q   <= vram_we_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
    end
  end

  assign vram_we         = vram_we_q;
  assign vram_addr       = vram_addr_q;
  assign vram_write_data = vram_data_q;

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (last_pix) begin
      state_d = ST_FLUSH;
    end else if (sof_v) begin
      // Restarting from FLUSH keeps queued old-frame entries; they drain first.
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_RUN:   state_d = ST_RUN;
        // Wait for the final registered write cycle to finish as well.
        ST_FLUSH: if (fifo_empty && !vram_we_q) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Overflow counter
  // ---------------------------------------------------------------------------
`ifdef VRAM_WRITER_OVF_CNT_EN
  logic        drop;
  logic [15:0] ovf_q, ovf_d;

  always_comb begin
    drop  = want_push && fifo_full && !pop;
    ovf_d = ovf_q;
    if (sof_v) begin
      ovf_d = drop ? 16'd1 : '0;
    end else if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_vram_writer.sv
module tb_vram_writer;

  logic        clk;
  logic        reset;
  logic        pix_valid;
  logic [29:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        wr_slot;
  logic [18:0] vram_addr;
  logic [35:0] vram_write_data;
  logic        vram_we;
  logic        busy;
  logic        frame_done;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;

  // Write monitor state (sampled on the falling edge)
  int          wr_count = 0;
  int          fd_count = 0;
  int          bad_x    = 0;
  longint      addr_sum = 0;
  logic [18:0] last_addr = '0;
  logic [35:0] last_data = '0;
  logic [18:0] hist [4];

  vram_writer #(
    .WIDTH      (640),
    .HEIGHT     (4),
    .FIFO_DEPTH (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .pix_sof         (pix_sof),
    .pix_eol         (pix_eol),
    .wr_slot         (wr_slot),
    .vram_addr       (vram_addr),
    .vram_write_data (vram_write_data),
    .vram_we         (vram_we),
    .busy            (busy),
    .frame_done      (frame_done),
    .ovf_count       (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (vram_we === 1'b1) begin
      wr_count  = wr_count + 1;
      last_addr = vram_addr;
      last_data = vram_write_data;
      addr_sum  = addr_sum + longint'(vram_addr);
      if (vram_addr[9:0] >= 10'd640) bad_x = bad_x + 1;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = vram_addr;
    end
    if (frame_done === 1'b1) fd_count = fd_count + 1;
  end

  function automatic logic [29:0] pix_of(input int x, input int y);
    logic [9:0] xs, ys;
    xs = 10'(x);
    ys = 10'(y);
    return {ys, xs, 10'h155};
  endfunction

  function automatic logic [18:0] addr_of(input int x, input int y);
    logic [9:0] xs;
    logic [8:0] ys;
    xs = 10'(x);
    ys = 9'(y);
    return {ys, xs};
  endfunction

  // Present one pixel; it is sampled at the next rising edge. Returns 1 ns after that edge.
  task automatic drive(input logic s, input logic e, input logic [29:0] d);
    pix_valid = 1'b1;
    pix_sof   = s;
    pix_eol   = e;
    pix_data  = d;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", vram_we); end
    checks++; if (vram_addr !== 19'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", vram_addr); end
    checks++; if (vram_write_data !== 36'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", vram_write_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL reset_ovf: got %0d expected 0", ovf_count); end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_single_pixel;
    wr_slot = 1'b1;
    drive(1'b1, 1'b1, pix_of(0, 0));      // (0,0), eol -> y=1
    drive(1'b0, 1'b1, pix_of(0, 1));      // (0,1), eol -> y=2
    for (int x = 0; x < 5; x++) drive(1'b0, 1'b0, pix_of(x, 2));
    idle(4);
    drive(1'b0, 1'b0, pix_of(5, 2));      // push edge
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL lat_we_early: got %b expected 0", vram_we); end
    idle(1);                              // pop edge
    checks++; if (vram_we !== 1'b1) begin errors++; $display("FAIL lat_we: got %b expected 1", vram_we); end
    checks++; if (vram_addr !== 19'h00805) begin errors++; $display("FAIL lat_addr: got %h expected 00805", vram_addr); end
    checks++; if (vram_write_data !== {6'd0, pix_of(5, 2)}) begin errors++; $display("FAIL lat_data: got %h expected %h", vram_write_data, {6'd0, pix_of(5, 2)}); end
    idle(1);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL lat_we_single: got %b expected 0", vram_we); end
  endtask

  task automatic test_full_frame;
    int     base_wr, base_fd;
    longint base_sum, exp_sum;
    base_wr  = wr_count;
    base_fd  = fd_count;
    base_sum = addr_sum;
    exp_sum  = 0;
    wr_slot  = 1'b1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 640; x++) begin
        drive(x == 0 && y == 0, x == 639, pix_of(x, y));
        exp_sum = exp_sum + longint'(addr_of(x, y));
      end
    end
    idle(12);
    checks++; if (wr_count - base_wr != 2560) begin errors++; $display("FAIL frame_writes: got %0d expected 2560", wr_count - base_wr); end
    checks++; if (last_addr !== 19'h00e7f) begin errors++; $display("FAIL frame_last_addr: got %h expected 00e7f", last_addr); end
    checks++; if (last_data !== {6'd0, pix_of(639, 3)}) begin errors++; $display("FAIL frame_last_data: got %h expected %h", last_data, {6'd0, pix_of(639, 3)}); end
    checks++; if (addr_sum - base_sum != exp_sum) begin errors++; $display("FAIL frame_addr_sum: got %0d expected %0d", addr_sum - base_sum, exp_sum); end
    checks++; if (fd_count - base_fd != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_count - base_fd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overflow;
    int          base_wr;
    logic [15:0] exp_ovf;
`ifdef VRAM_WRITER_OVF_CNT_EN
    exp_ovf = 16'd4;
`else
    exp_ovf = 16'd0;
`endif
    wr_slot = 1'b0;
    idle(1);
    base_wr = wr_count;
    for (int x = 0; x < 20; x++) drive(x == 0, 1'b0, pix_of(x, 0));
    idle(2);
    checks++; if (ovf_count !== exp_ovf) begin errors++; $display("FAIL ovf_count: got %0d expected %0d", ovf_count, exp_ovf); end
    checks++; if (wr_count - base_wr != 0) begin errors++; $display("FAIL ovf_no_writes: got %0d expected 0", wr_count - base_wr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_busy: got %b expected 1", busy); end
    wr_slot = 1'b1;
    idle(24);
    checks++; if (wr_count - base_wr != 16) begin errors++; $display("FAIL ovf_drain_writes: got %0d expected 16", wr_count - base_wr); end
    checks++; if (last_addr !== 19'h0000f) begin errors++; $display("FAIL ovf_drain_last: got %h expected 0000f", last_addr); end
  endtask

  task automatic test_long_line;
    int base_wr, base_bad;
    wr_slot  = 1'b1;
    base_wr  = wr_count;
    base_bad = bad_x;
    for (int x = 0; x < 700; x++) drive(x == 0, x == 699, pix_of(x, 0));
    idle(4);
    checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL line_ovf_cleared: got %0d expected 0", ovf_count); end
    checks++; if (wr_count - base_wr != 640) begin errors++; $display("FAIL line_writes: got %0d expected 640", wr_count - base_wr); end
    checks++; if (last_addr !== 19'h0027f) begin errors++; $display("FAIL line_last_addr: got %h expected 0027f", last_addr); end
    checks++; if (bad_x - base_bad != 0) begin errors++; $display("FAIL line_out_of_window: got %0d expected 0", bad_x - base_bad); end
    drive(1'b0, 1'b0, pix_of(0, 1));
    idle(3);
    checks++; if (last_addr !== 19'h00400) begin errors++; $display("FAIL line_next_start: got %h expected 00400", last_addr); end
    checks++; if (last_data !== {6'd0, pix_of(0, 1)}) begin errors++; $display("FAIL line_next_data: got %h expected %h", last_data, {6'd0, pix_of(0, 1)}); end
  endtask

  task automatic test_sof_in_flush;
    int base_wr, base_fd;
    wr_slot = 1'b1;
    idle(2);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 640; x++) begin
        // Starve the last three pixels of slots so they stay queued into FLUSH.
        wr_slot = !(y == 3 && x >= 638);
        drive(x == 0 && y == 0, x == 639, pix_of(x, y));
      end
    end
    base_wr = wr_count;
    base_fd = fd_count;
    drive(1'b1, 1'b0, pix_of(0, 0));
    wr_slot = 1'b1;
    idle(10);
    checks++; if (wr_count - base_wr != 4) begin errors++; $display("FAIL flush_writes: got %0d expected 4", wr_count - base_wr); end
    checks++; if (hist[3] !== 19'h00e7d) begin errors++; $display("FAIL flush_old0: got %h expected 00e7d", hist[3]); end
    checks++; if (hist[2] !== 19'h00e7e) begin errors++; $display("FAIL flush_old1: got %h expected 00e7e", hist[2]); end
    checks++; if (hist[1] !== 19'h00e7f) begin errors++; $display("FAIL flush_old2: got %h expected 00e7f", hist[1]); end
    checks++; if (hist[0] !== 19'h00000) begin errors++; $display("FAIL flush_new_addr: got %h expected 00000", hist[0]); end
    checks++; if (fd_count - base_fd != 0) begin errors++; $display("FAIL flush_no_frame_done: got %0d expected 0", fd_count - base_fd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_restart_busy: got %b expected 1", busy); end
  endtask

  task automatic test_reset_mid_run;
    int base_wr;
    wr_slot = 1'b0;
    for (int x = 0; x < 8; x++) drive(x == 0, 1'b0, pix_of(x, 0));
    base_wr = wr_count;
    wr_slot = 1'b1;
    reset   = 1'b0;
    #1;
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rst_run_we: got %b expected 0", vram_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b expected 0", busy); end
    idle(3);
    reset = 1'b1;
    idle(10);
    checks++; if (wr_count - base_wr != 0) begin errors++; $display("FAIL rst_run_writes: got %0d expected 0", wr_count - base_wr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_idle: got %b expected 0", busy); end
  endtask

  initial begin
    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    wr_slot   = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    test_reset;
    test_single_pixel;
    test_full_frame;
    test_overflow;
    test_long_line;
    test_sof_in_flush;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
